// File: rtl/not_bank_pkg.sv
// Shared constants for the not_bank inverter bank: mode encodings and config FSM states.
package not_bank_pkg;

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_INV   = 2'b01;
    localparam logic [1:0] MODE_MASK  = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_APPLY = 1'b1;

    function automatic logic is_blink(input logic [1:0] mode);
        return mode == MODE_BLINK;
    endfunction

endpackage

// File: rtl/not_bank_phase_div.sv
// Blink phase generator: counts 0..period and toggles phase at each wrap while enabled.
module phase_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] period,
    output logic             phase
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // Compare with >= so a stray count above period still wraps instead of overflowing.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr || !en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q >= period) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/not_bank.sv
// Registered WIDTH-bit inverter bank with pass/invert/mask/blink modes and a
// one-cycle config handshake that loads the mask and blink period.
module not_bank
    import not_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic [DIV_W-1:0] cfg_period,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             dout_valid,
    output logic [WIDTH-1:0] dout,
    output logic             phase
);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic [WIDTH-1:0] inv;
    logic             cfg_accept;
    logic             phase_w;

    assign cfg_ready  = (state_q == ST_IDLE);
    assign cfg_accept = cfg_valid && cfg_ready;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        period_d = period_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_accept) begin
                    mask_d   = cfg_mask;
                    period_d = cfg_period;
                    state_d  = ST_APPLY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Uses the phase register as it stands this cycle, i.e. before any toggle.
    always_comb begin
        inv = '0;
        case (mode)
            MODE_PASS:  inv = '0;
            MODE_INV:   inv = '1;
            MODE_MASK:  inv = mask_q;
            default:    inv = phase_w ? mask_q : '0;
        endcase
    end

    always_comb begin
        dout_d       = din_valid ? (din ^ inv) : dout_q;
        dout_valid_d = din_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mask_q       <= '1;
            period_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            period_q     <= period_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    phase_div #(
        .DIV_W (DIV_W)
    ) u_phase_div (
        .clk    (clk),
        .rst    (rst),
        .en     (is_blink(mode)),
        .clr    (cfg_accept),
        .period (period_q),
        .phase  (phase_w)
    );

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign phase      = phase_w;

endmodule

// File: tb/tb_not_bank.sv
// Bench for not_bank: cycle table with a dout scoreboard, plus a reset-during-blink sequence.
module tb_not_bank;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_mask;
    logic [7:0] cfg_period;
    logic       din_valid;
    logic [7:0] din;
    logic       dout_valid;
    logic [7:0] dout;
    logic       phase;

    not_bank #(.WIDTH(8), .DIV_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mask   (cfg_mask),
        .cfg_period (cfg_period),
        .din_valid  (din_valid),
        .din        (din),
        .dout_valid (dout_valid),
        .dout       (dout),
        .phase      (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       cfg;
        logic [7:0] mask;
        logic [7:0] per;
        logic [1:0] mode;
        logic       dv;
        logic [7:0] din;
        logic [7:0] exp;
        logic       rdy;
        logic       ph;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         total = 0;
    int         bad   = 0;
    logic       exp_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic c, input logic [7:0] m, input logic [7:0] p,
                       input logic [1:0] md, input logic dv, input logic [7:0] d,
                       input logic [7:0] e, input logic r, input logic ph);
        vec_t v;
        v.cfg = c; v.mask = m; v.per = p; v.mode = md; v.dv = dv;
        v.din = d; v.exp = e; v.rdy = r; v.ph = ph;
        vecs.push_back(v);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) exp_v <= 1'b0;
        else     exp_v <= din_valid;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        chk("dout_valid", {31'd0, dout_valid}, {31'd0, exp_v});
        if (dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("dout", {24'd0, dout}, {24'd0, e});
            end
        end
    end

    initial begin
        rst = 1'b1; mode = 2'b00; cfg_valid = 1'b0; cfg_mask = 8'h00;
        cfg_period = 8'h00; din_valid = 1'b0; din = 8'h00;

        #1;
        chk("rst_dout", {24'd0, dout}, 32'h00);
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_phase", {31'd0, phase}, 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_dout", {24'd0, dout}, 32'h00);
        chk("post_rst_ready", {31'd0, cfg_ready}, 32'd1);

        //    cfg mask   per   mode   dv din    exp    rdy ph
        add(0, 8'h00, 8'd0, 2'b10, 1, 8'h0F, 8'hF0, 1, 0);
        add(1, 8'h3C, 8'd0, 2'b00, 0, 8'h00, 8'h00, 1, 0);
        add(0, 8'h00, 8'd0, 2'b00, 1, 8'hA5, 8'hA5, 0, 0);
        add(0, 8'h00, 8'd0, 2'b01, 1, 8'hA5, 8'h5A, 1, 0);
        add(0, 8'h00, 8'd0, 2'b10, 1, 8'hA5, 8'h99, 1, 0);
        for (int i = 0; i < 3; i++)
            add(0, 8'h00, 8'd0, 2'b10, 0, 8'h00, 8'h00, 1, 0);
        add(0, 8'h00, 8'd0, 2'b10, 1, 8'h00, 8'h3C, 1, 0);
        // Accept cycle uses the old mask; the held request during APPLY is ignored.
        add(1, 8'h0F, 8'd0, 2'b10, 1, 8'hFF, 8'hC3, 1, 0);
        add(1, 8'h55, 8'd0, 2'b10, 1, 8'hFF, 8'hF0, 0, 0);
        add(0, 8'h00, 8'd0, 2'b10, 1, 8'hFF, 8'hF0, 1, 0);
        add(1, 8'hFF, 8'd2, 2'b00, 0, 8'h00, 8'h00, 1, 0);
        for (int i = 0; i < 9; i++) begin
            logic ph;
            ph = (i >= 3 && i < 6);
            add(0, 8'h00, 8'd0, 2'b11, 1, 8'h00, ph ? 8'hFF : 8'h00, (i != 0), ph);
        end
        add(1, 8'hFF, 8'd0, 2'b00, 0, 8'h00, 8'h00, 1, 1);
        for (int i = 0; i < 5; i++) begin
            logic ph;
            ph = i[0];
            add(0, 8'h00, 8'd0, 2'b11, 1, 8'h00, ph ? 8'hFF : 8'h00, (i != 0), ph);
        end
        add(0, 8'h00, 8'd0, 2'b00, 1, 8'h00, 8'h00, 1, 1);
        add(0, 8'h00, 8'd0, 2'b00, 1, 8'h00, 8'h00, 1, 0);
        add(0, 8'h00, 8'd0, 2'b10, 1, 8'h12, 8'hED, 1, 0);

        foreach (vecs[k]) begin
            cfg_valid  = vecs[k].cfg;
            cfg_mask   = vecs[k].mask;
            cfg_period = vecs[k].per;
            mode       = vecs[k].mode;
            din_valid  = vecs[k].dv;
            din        = vecs[k].din;
            chk($sformatf("ready_row%0d", k), {31'd0, cfg_ready}, {31'd0, vecs[k].rdy});
            chk($sformatf("phase_row%0d", k), {31'd0, phase}, {31'd0, vecs[k].ph});
            if (vecs[k].dv) sb.push_back(vecs[k].exp);
            step();
        end

        // Reset in the middle of a blink with phase=1.
        cfg_valid = 1'b1; cfg_mask = 8'h0F; cfg_period = 8'd3; mode = 2'b00; din_valid = 1'b0;
        chk("blk_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        step();
        cfg_valid = 1'b0; mode = 2'b11; din_valid = 1'b1; din = 8'h00;
        for (int i = 0; i < 6; i++) begin
            logic ph;
            ph = (i >= 4);
            chk("blk_phase", {31'd0, phase}, {31'd0, ph});
            sb.push_back(ph ? 8'h0F : 8'h00);
            step();
        end
        chk("pre_rst_phase", {31'd0, phase}, 32'd1);
        rst = 1'b1;
        din_valid = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_dout", {24'd0, dout}, 32'h00);
        chk("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("mid_rst_phase", {31'd0, phase}, 32'd0);
        chk("mid_rst_ready", {31'd0, cfg_ready}, 32'd1);
        step();
        step();
        rst = 1'b0;
        mode = 2'b11; din_valid = 1'b1; din = 8'h0F;
        chk("rel_phase0", {31'd0, phase}, 32'd0);
        sb.push_back(8'h0F);
        step();
        chk("rel_phase1", {31'd0, phase}, 32'd1);
        sb.push_back(8'hF0);
        step();
        mode = 2'b00; din_valid = 1'b0;
        step();
        step();
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
